voice_sync_fifo: RTL and testbench

Single-clock, parametrised sample FIFO for the voice-change audio path: buffers PCM samples between the I2S/ADC capture side and the pitch/formant processing pipeline when both run on the same clock. It generalises the existing dual-clock voice-change FIFO to arbitrary width and depth and adds runtime-programmable thresholds, an optional output register, a flush control, and sticky overflow/underflow error flags. The storage array infers block RAM; the control logic is fully synchronous.

---
 rtl/voice_sync_fifo_if.sv | 23 ++
 rtl/voice_sync_fifo.sv | 119 +++++++++++
 tb/tb_voice_sync_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_sync_fifo_if.sv
// Sample stream bundle between the capture side (master) and the FIFO (slave).
// Carries write/read requests, read data with its valid pulse, and full/empty status.
interface voice_sync_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_empty;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, rd_data, rd_valid, rd_empty
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, rd_data, rd_valid, rd_empty
  );
endinterface

// File: rtl/voice_sync_fifo.sv
// Single-clock PCM sample FIFO with programmable thresholds, flush and sticky error flags.
// Latency: write visible next cycle; read data 1 cycle after accept (2 with OUTPUT_REG=1).
// Backpressure: writes dropped while full, reads dropped while empty; both set a sticky flag.
module voice_sync_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 11,
  parameter int OUTPUT_REG  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  voice_sync_fifo_if.slave     fifo,
  input  logic                 flush,
  input  logic [DEPTH_WIDTH:0] almost_full_num,
  input  logic [DEPTH_WIDTH:0] almost_empty_num,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [DEPTH_WIDTH:0] water_level,
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [DEPTH_WIDTH:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]  mem [0:(1<<DEPTH_WIDTH)-1];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   level;
  logic                   full;
  logic                   empty;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   ovf_set;
  logic                   udf_set;
  logic [DATA_WIDTH-1:0]  ram_dat;
  logic                   ram_vld;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  // Flush and reset both swallow the requests of their cycle without flagging them.
  assign wr_acc  = rst_n && !flush && fifo.wr_en && !full;
  assign rd_acc  = rst_n && !flush && fifo.rd_en && !empty;
  assign ovf_set = !flush && fifo.wr_en && full;
  assign udf_set = !flush && fifo.rd_en && empty;

  assign fifo.wr_full  = full;
  assign fifo.rd_empty = empty;
  assign almost_full   = (level >= almost_full_num);
  assign almost_empty  = (level <= almost_empty_num);
  assign water_level   = level;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
      // A new violation outranks a clear arriving in the same cycle.
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= udf_set | (underflow & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_dat <= '0;
      ram_vld <= 1'b0;
    end else begin
      ram_vld <= rd_acc;
      if (rd_acc) ram_dat <= mem[rd_ptr];
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_dat;
      logic                  out_vld;

      // A read already in the RAM stage is dropped if a flush lands behind it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_dat <= '0;
          out_vld <= 1'b0;
        end else begin
          out_vld <= ram_vld && !flush;
          if (ram_vld && !flush) out_dat <= ram_dat;
        end
      end

      assign fifo.rd_data  = out_dat;
      assign fifo.rd_valid = out_vld;
    end else begin : g_no_out_reg
      assign fifo.rd_data  = ram_dat;
      assign fifo.rd_valid = ram_vld;
    end
  endgenerate

endmodule

// File: tb/tb_voice_sync_fifo.sv
// Scoreboard bench: a shallow FIFO (depth 16, no output reg) and a deep one (depth 1024, output reg).
// Stimulus pushes expected read words with their due cycle; a negedge monitor pops and compares.
module tb_voice_sync_fifo;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_cnt  = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  voice_sync_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  voice_sync_fifo_if #(.DATA_WIDTH(DW)) l_if ();

  logic        s_flush = 1'b0, s_err_clr = 1'b0;
  logic        s_af, s_ae, s_ovf, s_udf;
  logic [4:0]  s_afn = 5'd12, s_aen = 5'd3, s_lvl;
  logic        l_flush = 1'b0, l_err_clr = 1'b0;
  logic        l_af, l_ae, l_ovf, l_udf;
  logic [10:0] l_afn = 11'd1000, l_aen = 11'd2, l_lvl;

  voice_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(4), .OUTPUT_REG(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .fifo(s_if.slave), .flush(s_flush),
    .almost_full_num(s_afn), .almost_empty_num(s_aen),
    .almost_full(s_af), .almost_empty(s_ae), .water_level(s_lvl),
    .err_clr(s_err_clr), .overflow(s_ovf), .underflow(s_udf)
  );

  voice_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(10), .OUTPUT_REG(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .fifo(l_if.slave), .flush(l_flush),
    .almost_full_num(l_afn), .almost_empty_num(l_aen),
    .almost_full(l_af), .almost_empty(l_ae), .water_level(l_lvl),
    .err_clr(l_err_clr), .overflow(l_ovf), .underflow(l_udf)
  );

  typedef struct {
    logic [15:0] dat;
    int          due;
  } exp_t;

  exp_t        sb [2][$];
  logic [15:0] mq [2][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp_v, cyc_cnt);
    end
  endtask

  task automatic drive(input int d, input bit we, input logic [15:0] wd, input bit re, input bit fl);
    if (d == 0) begin
      s_if.wr_en = we; s_if.wr_data = wd; s_if.rd_en = re; s_flush = fl;
    end else begin
      l_if.wr_en = we; l_if.wr_data = wd; l_if.rd_en = re; l_flush = fl;
    end
  endtask

  task automatic prune(input int d);
    for (int i = sb[d].size() - 1; i >= 0; i--)
      if (sb[d][i].due > cyc_cnt) sb[d].delete(i);
  endtask

  // One clock of stimulus on FIFO d; the other FIFO idles.
  task automatic cyc(input int d, input bit we, input logic [15:0] wd, input bit re, input bit fl);
    int   dep;
    int   lat;
    bit   wacc;
    bit   racc;
    exp_t e;
    dep = (d == 0) ? 16 : 1024;
    lat = (d == 0) ? 1 : 2;
    drive(d, we, wd, re, fl);
    drive(1 - d, 1'b0, 16'h0, 1'b0, 1'b0);
    if (fl) begin
      mq[d].delete();
      prune(d);
    end else begin
      wacc = we && (mq[d].size() < dep);
      racc = re && (mq[d].size() > 0);
      if (racc) begin
        e.dat = mq[d].pop_front();
        e.due = cyc_cnt + lat;
        sb[d].push_back(e);
      end
      if (wacc) mq[d].push_back(wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      prune(d);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset();
    chk("s_rst_empty", 32'(s_if.rd_empty), 1);
    chk("s_rst_full", 32'(s_if.wr_full), 0);
    chk("s_rst_ae", 32'(s_ae), 1);
    chk("s_rst_af", 32'(s_af), 0);
    chk("s_rst_level", 32'(s_lvl), 0);
    chk("s_rst_valid", 32'(s_if.rd_valid), 0);
    chk("s_rst_data", 32'(s_if.rd_data), 0);
    chk("s_rst_ovf", 32'(s_ovf), 0);
    chk("s_rst_udf", 32'(s_udf), 0);
    chk("l_rst_empty", 32'(l_if.rd_empty), 1);
    chk("l_rst_full", 32'(l_if.wr_full), 0);
    chk("l_rst_ae", 32'(l_ae), 1);
    chk("l_rst_af", 32'(l_af), 0);
    chk("l_rst_level", 32'(l_lvl), 0);
    chk("l_rst_valid", 32'(l_if.rd_valid), 0);
    chk("l_rst_data", 32'(l_if.rd_data), 0);
    chk("l_rst_ovf", 32'(l_ovf), 0);
    chk("l_rst_udf", 32'(l_udf), 0);
  endtask

  task automatic mon(input int d, input logic v, input logic [15:0] dat);
    exp_t e;
    if (v === 1'b1) begin
      if (sb[d].size() == 0) begin
        chk($sformatf("dut%0d_unexpected_rd_valid", d), 32'(v), 0);
      end else begin
        e = sb[d].pop_front();
        chk($sformatf("dut%0d_rd_data", d), 32'(dat), 32'(e.dat));
        chk($sformatf("dut%0d_rd_cycle", d), cyc_cnt, e.due);
      end
    end else if (sb[d].size() > 0 && sb[d][0].due <= cyc_cnt) begin
      e = sb[d].pop_front();
      chk($sformatf("dut%0d_missing_rd_valid", d), 32'(v), 1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, s_if.rd_valid, s_if.rd_data);
      mon(1, l_if.rd_valid, l_if.rd_data);
    end
  end

  initial begin
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    do_reset();
    chk_reset();

    // Five words in, five out, on both FIFOs.
    for (int d = 0; d < 2; d++) begin
      for (int i = 1; i <= 5; i++) cyc(d, 1'b1, 16'(i), 1'b0, 1'b0);
      chk($sformatf("dut%0d_level5", d), 32'((d == 0) ? s_lvl : 5'(l_lvl)), 5);
      repeat (5) cyc(d, 1'b0, 16'h0, 1'b1, 1'b0);
      idle(3);
      chk($sformatf("dut%0d_level0", d), 32'((d == 0) ? s_lvl : 5'(l_lvl)), 0);
      chk($sformatf("dut%0d_empty_end", d), 32'((d == 0) ? s_if.rd_empty : l_if.rd_empty), 1);
    end

    // Thresholds 12/3 across every level 0..16, then a 17th write into a full FIFO.
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("s_fill_level_%0d", i), 32'(s_lvl), 32'(i));
      chk($sformatf("s_fill_ae_%0d", i), 32'(s_ae), (i <= 3) ? 1 : 0);
      chk($sformatf("s_fill_af_%0d", i), 32'(s_af), (i >= 12) ? 1 : 0);
      chk($sformatf("s_fill_full_%0d", i), 32'(s_if.wr_full), (i == 16) ? 1 : 0);
      chk($sformatf("s_fill_ovf_%0d", i), 32'(s_ovf), 0);
      cyc(0, 1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
    end
    chk("s_over_level", 32'(s_lvl), 16);
    chk("s_over_full", 32'(s_if.wr_full), 1);
    chk("s_over_ovf", 32'(s_ovf), 1);
    s_err_clr = 1'b1; idle(1); s_err_clr = 1'b0;
    chk("s_errclr_ovf", 32'(s_ovf), 0);

    // Full with simultaneous read and write: read wins, write flagged.
    cyc(0, 1'b1, 16'hDEAD, 1'b1, 1'b0);
    chk("s_fullrw_level", 32'(s_lvl), 15);
    chk("s_fullrw_ovf", 32'(s_ovf), 1);
    chk("s_fullrw_full", 32'(s_if.wr_full), 0);
    cyc(0, 1'b1, 16'h0110, 1'b0, 1'b0);
    s_err_clr = 1'b1; cyc(0, 1'b1, 16'hDEAD, 1'b0, 1'b0); s_err_clr = 1'b0;
    chk("s_set_beats_clr", 32'(s_ovf), 1);
    s_err_clr = 1'b1; idle(1); s_err_clr = 1'b0;
    chk("s_clr_ovf2", 32'(s_ovf), 0);

    // Drain, then simultaneous read and write on empty.
    repeat (16) cyc(0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("s_drain_level", 32'(s_lvl), 0);
    chk("s_drain_udf", 32'(s_udf), 0);
    cyc(0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("s_emptyrw_level", 32'(s_lvl), 1);
    chk("s_emptyrw_udf", 32'(s_udf), 1);
    cyc(0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("s_emptyrw_drain", 32'(s_lvl), 0);

    // Flush at level 8 with a write in the same cycle.
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 16'(16'h200 + i), 1'b0, 1'b0);
    chk("s_preflush_level", 32'(s_lvl), 8);
    cyc(0, 1'b1, 16'h5555, 1'b0, 1'b1);
    chk("s_flush_level", 32'(s_lvl), 0);
    chk("s_flush_empty", 32'(s_if.rd_empty), 1);
    chk("s_flush_udf_kept", 32'(s_udf), 1);
    chk("s_flush_ovf_kept", 32'(s_ovf), 0);
    cyc(0, 1'b1, 16'h7777, 1'b0, 1'b0);
    cyc(0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(3);

    // Output-register FIFO: a flush right behind an accepted read cancels it.
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, 16'(16'h300 + i), 1'b0, 1'b0);
    cyc(1, 1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("l_flush_valid", 32'(l_if.rd_valid), 0);
    chk("l_flush_level", 32'(l_lvl), 0);
    idle(3);

    // Pointer wrap on the 1024-deep FIFO.
    do_reset();
    for (int i = 0; i < 1000; i++) cyc(1, 1'b1, 16'(i), 1'b0, 1'b0);
    chk("l_wrap_level1000", 32'(l_lvl), 1000);
    chk("l_wrap_af", 32'(l_af), 1);
    repeat (600) cyc(1, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("l_wrap_level400", 32'(l_lvl), 400);
    for (int i = 0; i < 600; i++) cyc(1, 1'b1, 16'(1000 + i), 1'b0, 1'b0);
    chk("l_wrap_level1000b", 32'(l_lvl), 1000);
    repeat (1000) cyc(1, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(4);
    chk("l_wrap_level0", 32'(l_lvl), 0);

    // Reset in the middle of traffic on both FIFOs.
    cyc(0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 16'(16'h31 + i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1, 1'b1, 16'(16'h41 + i), 1'b0, 1'b0);
    cyc(0, 1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("s_pre_rst_udf", 32'(s_udf), 1);
    do_reset();
    chk_reset();

    idle(5);
    chk("sb0_drained", sb[0].size(), 0);
    chk("sb1_drained", sb[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
